// File: rtl/pwm_generator.sv
// Shared 8-bit PWM generator: prescaled period counter, wrap-shadowed duty cycle,
// and 16 registered pins selected between low, static high, or the PWM waveform.
module pwm_generator #(
  parameter int CLK_DIV = 13
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  en_reg_out_7_0,
  input  logic [7:0]  en_reg_out_15_8,
  input  logic [7:0]  en_reg_pwm_7_0,
  input  logic [7:0]  en_reg_pwm_15_8,
  input  logic [7:0]  pwm_duty_cycle,
  output logic [15:0] out,
  output logic        period_start
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(CLK_DIV - 1);

  logic [PW-1:0] prescaler_r;
  logic [7:0]    pwm_cnt_r;
  logic [7:0]    duty_q_r;
  logic          tick_s;
  logic          wrap_s;
  logic          pwm_sig_s;
  logic [15:0]   en_out_s;
  logic [15:0]   en_pwm_s;
  logic [15:0]   out_next_s;

  assign en_out_s  = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm_s  = {en_reg_pwm_15_8, en_reg_pwm_7_0};
  assign tick_s    = (prescaler_r == PS_LAST);
  assign wrap_s    = tick_s && (pwm_cnt_r == 8'hFF);
  // Full scale is forced high so the 255->0 wrap cycle never dips low.
  assign pwm_sig_s = (duty_q_r == 8'hFF) || (pwm_cnt_r < duty_q_r);

  // Prescaler: counts 0..CLK_DIV-1 and produces one tick per wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler_r <= {PW{1'b0}};
    end else if (tick_s) begin
      prescaler_r <= {PW{1'b0}};
    end else begin
      prescaler_r <= prescaler_r + 1'b1;
    end
  end

  // Period counter and duty shadow; the shadow only loads on the period wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt_r <= 8'd0;
      duty_q_r  <= 8'd0;
    end else begin
      if (tick_s) begin
        pwm_cnt_r <= pwm_cnt_r + 8'd1;
      end
      if (wrap_s) begin
        duty_q_r <= pwm_duty_cycle;
      end
    end
  end

  // Per-pin source select: disabled pins low, PWM pins follow the waveform, others high.
  always_comb begin
    out_next_s = 16'h0000;
    for (int i = 0; i < 16; i++) begin
      if (!en_out_s[i]) begin
        out_next_s[i] = 1'b0;
      end else if (en_pwm_s[i]) begin
        out_next_s[i] = pwm_sig_s;
      end else begin
        out_next_s[i] = 1'b1;
      end
    end
  end

  // Registered pin drive and period marker.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out          <= 16'h0000;
      period_start <= 1'b0;
    end else begin
      out          <= out_next_s;
      period_start <= wrap_s;
    end
  end

endmodule

// File: tb/tb_pwm_generator.sv
// Directed bench for pwm_generator with CLK_DIV=13 (period 3328 clk cycles).
module tb_pwm_generator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  e_o_lo, e_o_hi, e_p_lo, e_p_hi, duty;
  logic [15:0] out;
  logic        period_start;
  int          n_cmp = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  pwm_generator #(.CLK_DIV(13)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .en_reg_out_7_0  (e_o_lo),
    .en_reg_out_15_8 (e_o_hi),
    .en_reg_pwm_7_0  (e_p_lo),
    .en_reg_pwm_15_8 (e_p_hi),
    .pwm_duty_cycle  (duty),
    .out             (out),
    .period_start    (period_start)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h (%0d) expected 0x%0h (%0d)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic set_en(input logic [15:0] eo, input logic [15:0] ep);
    e_o_lo = eo[7:0];
    e_o_hi = eo[15:8];
    e_p_lo = ep[7:0];
    e_p_hi = ep[15:8];
  endtask

  // Advance negedge by negedge until period_start is seen; returns steps taken, -1 on timeout.
  task automatic wait_ps(output int steps);
    int k;
    k = 0;
    steps = -1;
    while (k < 4000) begin
      @(negedge clk);
      k++;
      if (period_start === 1'b1) begin
        steps = k;
        break;
      end
    end
    check("wait_ps_timeout", (steps > 0) ? 32'd1 : 32'd0, 32'd1);
  endtask

  initial begin
    int n, hi, lo, bad, ps_at;

    // Reset held: toggling inputs must not reach the pins
    set_en(16'hFFFF, 16'hFFFF);
    duty  = 8'hFF;
    rst_n = 1'b0;
    for (int r = 0; r < 3; r++) begin
      @(negedge clk);
      check("rst_out", {16'h0000, out}, 32'h0000_0000);
      check("rst_ps", {31'd0, period_start}, 32'd0);
      set_en(~{e_o_hi, e_o_lo}, 16'h5A5A);
      duty = ~duty;
    end

    // Release: pin0 static, pin1 PWM without output enable, pin3 PWM at duty 0x80
    @(negedge clk);
    set_en(16'h0009, 16'h000A);
    duty  = 8'h80;
    rst_n = 1'b1;
    @(negedge clk);
    check("static_latency", {16'h0000, out}, 32'h0000_0001);
    n = 1;
    bad = 0;
    while (period_start !== 1'b1 && n < 4000) begin
      if (out !== 16'h0001) bad++;
      @(negedge clk);
      n++;
    end
    check("first_ps_delay", n, 32'd3328);
    check("first_period_low", bad, 32'd0);
    check("ps_cycle_out", {16'h0000, out}, 32'h0000_0001);
    @(negedge clk);
    check("ps_one_cycle", {31'd0, period_start}, 32'd0);
    check("pwm_rise", {16'h0000, out}, 32'h0000_0009);

    // 50 % duty: high and low runs, period from pulse to pulse
    hi = 0;
    while (out[3] === 1'b1 && hi < 4000) begin
      hi++;
      @(negedge clk);
    end
    check("high_50", hi, 32'd1664);
    lo = 0;
    ps_at = -1;
    while (out[3] === 1'b0 && lo < 4000) begin
      lo++;
      if (period_start === 1'b1) ps_at = lo;
      @(negedge clk);
    end
    check("low_50", lo, 32'd1664);
    check("period_50", hi + ps_at, 32'd3328);

    // Duty 0x00 for a full period; 0xFF is written mid-period for the following one
    duty = 8'h00;
    wait_ps(n);
    duty = 8'hFF;
    hi = 0;
    bad = 0;
    for (int i = 1; i <= 3328; i++) begin
      @(negedge clk);
      if (out[3] === 1'b1) hi++;
      if ((out & 16'hFFF7) !== 16'h0001) bad++;
    end
    check("duty00_high", hi, 32'd0);
    check("static_pins_d00", bad, 32'd0);
    check("d00_ps_at_end", {31'd0, period_start}, 32'd1);

    // Duty 0xFF: constant high across the next wrap
    lo = 0;
    ps_at = -1;
    for (int i = 1; i <= 3330; i++) begin
      @(negedge clk);
      if (out[3] !== 1'b1) lo++;
      if (period_start === 1'b1) ps_at = i;
    end
    check("dutyff_low", lo, 32'd0);
    check("dutyff_wrap_ps", ps_at, 32'd3328);

    // Mid-period write: 0x40 period, write 0xC0 at pwm_cnt=100
    duty = 8'h40;
    wait_ps(n);
    hi = 0;
    for (int i = 1; i <= 3328; i++) begin
      @(negedge clk);
      if (i == 1305) duty = 8'hC0;
      if (out[3] === 1'b1) hi++;
    end
    check("mid_cur_high", hi, 32'd832);
    check("mid_ps", {31'd0, period_start}, 32'd1);
    hi = 0;
    for (int i = 1; i <= 3328; i++) begin
      @(negedge clk);
      if (out[3] === 1'b1) hi++;
    end
    check("mid_next_high", hi, 32'd2496);

    // Async reset at pwm_cnt=50 with every pin high
    set_en(16'hFFFF, 16'h00F0);
    for (int i = 1; i <= 656; i++) begin
      @(negedge clk);
    end
    check("pre_reset_all_high", {16'h0000, out}, 32'h0000_FFFF);
    #2 rst_n = 1'b0;
    #1 check("async_rst_out", {16'h0000, out}, 32'h0000_0000);
    check("async_rst_ps", {31'd0, period_start}, 32'd0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    n = 1;
    bad = 0;
    while (period_start !== 1'b1 && n < 4000) begin
      if (out !== 16'hFF0F) bad++;
      @(negedge clk);
      n++;
    end
    check("post_rst_ps_delay", n, 32'd3328);
    check("post_rst_pwm_low", bad, 32'd0);
    @(negedge clk);
    check("post_rst_resume", {16'h0000, out}, 32'h0000_FFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
